// File: rtl/rtc_bus_cycle_gen.sv
// Bus-cycle generator for the multiplexed address/data RTC interface: one start runs
// address phase, optional gap, then data phase. Optional err output under RTC_BUS_ERR_EN.
module rtc_bus_cycle_gen #(
  parameter int unsigned DW      = 8,
  parameter int unsigned T_SETUP = 1,
  parameter int unsigned T_PULSE = 6,
  parameter int unsigned T_HOLD  = 1,
  parameter int unsigned T_GAP   = 11
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          wr_i,
  input  logic [DW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [DW-1:0] bus_in_i,
  output logic          cs_n_o,
  output logic          rd_n_o,
  output logic          wr_n_o,
  output logic          ad_o,
  output logic [DW-1:0] bus_out_o,
  output logic          bus_oe_o,
  output logic [DW-1:0] rdata_o,
  output logic          busy_o,
`ifdef RTC_BUS_ERR_EN
  output logic          err_o,
`endif
  output logic          done_o
);

  localparam int unsigned T_M1  = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int unsigned T_M2  = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
  localparam int unsigned T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int unsigned CW    = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, A_SETUP, A_PULSE, A_HOLD, GAP, D_SETUP, D_PULSE, D_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DW-1:0] bus_out_q, bus_out_d;
  logic          cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, ad_q, ad_d;
  logic          bus_oe_q, bus_oe_d, busy_q, busy_d, done_q, done_d;
  logic          in_a, in_d;
`ifdef RTC_BUS_ERR_EN
  logic          err_q, err_d;
`endif

  // Next state, then pin values decoded from the state being entered so they register cleanly
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start_i) begin
        state_d = A_SETUP;
        cnt_d   = CW'(T_SETUP - 1);
        wr_d    = wr_i;
        addr_d  = addr_i;
        wdata_d = wdata_i;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      unique case (state_q)
        A_SETUP: begin state_d = A_PULSE; cnt_d = CW'(T_PULSE - 1); end
        A_PULSE: begin state_d = A_HOLD;  cnt_d = CW'(T_HOLD - 1);  end
        A_HOLD: begin
          if (T_GAP == 0) begin
            state_d = D_SETUP;
            cnt_d   = CW'(T_SETUP - 1);
          end else begin
            state_d = GAP;
            cnt_d   = CW'(T_GAP - 1);
          end
        end
        GAP:     begin state_d = D_SETUP; cnt_d = CW'(T_SETUP - 1); end
        D_SETUP: begin state_d = D_PULSE; cnt_d = CW'(T_PULSE - 1); end
        D_PULSE: begin
          state_d = D_HOLD;
          cnt_d   = CW'(T_HOLD - 1);
          if (!wr_q) rdata_d = bus_in_i;
        end
        default: begin state_d = IDLE; cnt_d = '0; done_d = 1'b1; end
      endcase
    end

    in_a      = (state_d == A_SETUP) || (state_d == A_PULSE) || (state_d == A_HOLD);
    in_d      = (state_d == D_SETUP) || (state_d == D_PULSE) || (state_d == D_HOLD);
    cs_n_d    = !(in_a || in_d);
    ad_d      = !in_a;
    bus_oe_d  = in_a || (in_d && wr_d);
    bus_out_d = in_a ? addr_d : ((in_d && wr_d) ? wdata_d : '0);
    wr_n_d    = !((state_d == A_PULSE) || ((state_d == D_PULSE) && wr_d));
    rd_n_d    = !((state_d == D_PULSE) && !wr_d);
    busy_d    = (state_d != IDLE);
`ifdef RTC_BUS_ERR_EN
    err_d     = start_i && busy_q;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      bus_out_q <= '0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      ad_q      <= 1'b1;
      bus_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef RTC_BUS_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      bus_out_q <= bus_out_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      ad_q      <= ad_d;
      bus_oe_q  <= bus_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef RTC_BUS_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  assign cs_n_o    = cs_n_q;
  assign rd_n_o    = rd_n_q;
  assign wr_n_o    = wr_n_q;
  assign ad_o      = ad_q;
  assign bus_out_o = bus_out_q;
  assign bus_oe_o  = bus_oe_q;
  assign rdata_o   = rdata_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
`ifdef RTC_BUS_ERR_EN
  assign err_o     = err_q;
`endif

endmodule

// File: tb/tb_rtc_bus_cycle_gen.sv
// Bench for rtc_bus_cycle_gen: default-timing instance plus a short-timing, no-gap instance,
// both checked cycle by cycle against a phase-arithmetic model of the transaction.
module tb_rtc_bus_cycle_gen;
  localparam int unsigned DW = 8;
  localparam int unsigned BS = 2, BP = 3, BH = 2, BG = 0;

  logic clk = 1'b0;
  logic rst_n;
  logic start, wr;
  logic [DW-1:0] addr, wdata, bus_in;
  always #5 clk = ~clk;

  logic cs_n_a, rd_n_a, wr_n_a, ad_a, oe_a, busy_a, done_a;
  logic cs_n_b, rd_n_b, wr_n_b, ad_b, oe_b, busy_b, done_b;
  logic [DW-1:0] bout_a, rdata_a, bout_b, rdata_b;
`ifdef RTC_BUS_ERR_EN
  logic err_a, err_b;
`endif

  rtc_bus_cycle_gen u_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .wr_i(wr), .addr_i(addr),
    .wdata_i(wdata), .bus_in_i(bus_in), .cs_n_o(cs_n_a), .rd_n_o(rd_n_a),
    .wr_n_o(wr_n_a), .ad_o(ad_a), .bus_out_o(bout_a), .bus_oe_o(oe_a),
    .rdata_o(rdata_a), .busy_o(busy_a),
`ifdef RTC_BUS_ERR_EN
    .err_o(err_a),
`endif
    .done_o(done_a)
  );

  rtc_bus_cycle_gen #(.T_SETUP(BS), .T_PULSE(BP), .T_HOLD(BH), .T_GAP(BG)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .wr_i(wr), .addr_i(addr),
    .wdata_i(wdata), .bus_in_i(bus_in), .cs_n_o(cs_n_b), .rd_n_o(rd_n_b),
    .wr_n_o(wr_n_b), .ad_o(ad_b), .bus_out_o(bout_b), .bus_oe_o(oe_b),
    .rdata_o(rdata_b), .busy_o(busy_b),
`ifdef RTC_BUS_ERR_EN
    .err_o(err_b),
`endif
    .done_o(done_b)
  );

  bit sel;
  int ts, tp, th, tg;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_rd;

  logic [6:0]    obs_ctl;
  logic [DW-1:0] obs_bus, obs_rd;
  assign obs_ctl = sel ? {cs_n_b, rd_n_b, wr_n_b, ad_b, oe_b, busy_b, done_b}
                       : {cs_n_a, rd_n_a, wr_n_a, ad_a, oe_a, busy_a, done_a};
  assign obs_bus = sel ? bout_b : bout_a;
  assign obs_rd  = sel ? rdata_b : rdata_a;
`ifdef RTC_BUS_ERR_EN
  logic obs_err;
  assign obs_err = sel ? err_b : err_a;
`endif

  localparam logic [6:0] IDLE_CTL = 7'b1111000;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // Control pins {cs_n,rd_n,wr_n,ad,oe,busy,done} at cycle k after the accepting edge
  function automatic logic [6:0] exp_ctl(input int k, input bit w);
    int p, l, j;
    bit s;
    p = ts + tp + th;
    l = 2 * p + tg;
    if (k >= 1 && k <= p) begin
      j = k - 1;
      s = (j >= ts) && (j < ts + tp);
      return {1'b0, 1'b1, !s, 1'b0, 1'b1, 1'b1, 1'b0};
    end else if (k > p && k <= p + tg) begin
      return {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    end else if (k > p + tg && k <= l) begin
      j = k - p - tg - 1;
      s = (j >= ts) && (j < ts + tp);
      return {1'b0, !(s && !w), !(s && w), 1'b1, w, 1'b1, 1'b0};
    end else if (k == l + 1) begin
      return {IDLE_CTL[6:1], 1'b1};
    end
    return IDLE_CTL;
  endfunction

  function automatic logic [DW-1:0] exp_bus(input int k, input bit w, input logic [DW-1:0] a,
                                           input logic [DW-1:0] d);
    int p;
    p = ts + tp + th;
    if (k >= 1 && k <= p) return a;
    if (k > p + tg && k <= 2 * p + tg && w) return d;
    return '0;
  endfunction

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      start  = 1'b0;
      bus_in = DW'($urandom);
      @(negedge clk);
      chk("idle_ctl", i, 32'(obs_ctl), 32'(IDLE_CTL));
      chk("idle_bus", i, 32'(obs_bus), 32'h0);
      chk("idle_rdata", i, 32'(obs_rd), 32'(exp_rd));
`ifdef RTC_BUS_ERR_EN
      chk("idle_err", i, 32'(obs_err), 32'h0);
`endif
    end
  endtask

  task automatic run_txn(input bit w, input logic [DW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] rin, input bit pre, input bit inject,
                         input int rst_at, input bit nxt, input bit nw,
                         input logic [DW-1:0] na, input logic [DW-1:0] nd);
    int l, lp;
    l  = 2 * (ts + tp + th) + tg;
    lp = ts + tp + th + tg + ts + tp;
    if (!pre) begin
      @(negedge clk);
      start = 1'b1; wr = w; addr = a; wdata = d;
    end
    for (int k = 1; k <= l + 1; k++) begin
      @(negedge clk);
      if (k == lp + 1 && !w) exp_rd = rin;
      chk("ctl", k, 32'(obs_ctl), 32'(exp_ctl(k, w)));
      chk("bus_out", k, 32'(obs_bus), 32'(exp_bus(k, w, a, d)));
      chk("rdata", k, 32'(obs_rd), 32'(exp_rd));
`ifdef RTC_BUS_ERR_EN
      chk("err", k, 32'(obs_err), 32'(inject && k == 11));
`endif
      start  = 1'b0;
      wr     = 1'($urandom);
      addr   = DW'($urandom);
      wdata  = DW'($urandom);
      bus_in = (k == lp) ? rin : DW'($urandom);
      if (inject && k == 10) start = 1'b1;
      if (nxt && k == l + 1) begin
        start = 1'b1; wr = nw; addr = na; wdata = nd;
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        exp_rd = '0;
        chk("rst_ctl", k, 32'(obs_ctl), 32'(IDLE_CTL));
        chk("rst_bus", k, 32'(obs_bus), 32'h0);
        chk("rst_rdata", k, 32'(obs_rd), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit pre, cw, nx, nw;
    logic [DW-1:0] ca, cd, na, nd;
    rst_n = 1'b1;
    sel = 1'b0;
    ts = 1; tp = 6; th = 1; tg = 11;
    exp_rd = '0;
    start = 1'b0; wr = 1'b0; addr = '0; wdata = '0; bus_in = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctl", 0, 32'(obs_ctl), 32'(IDLE_CTL));
    chk("reset_bus", 0, 32'(obs_bus), 32'h0);
    chk("reset_rdata", 0, 32'(obs_rd), 32'h0);
    rst_n = 1'b1;
    idle_check(2);

    run_txn(1'b1, 8'h21, 8'h5A, 8'h00, 1'b0, 1'b0, -1, 1'b0, 1'b0, '0, '0);
    idle_check(2);
    run_txn(1'b0, 8'h04, 8'h99, 8'hC3, 1'b0, 1'b0, -1, 1'b0, 1'b0, '0, '0);
    idle_check(2);
    run_txn(1'b0, 8'h33, 8'h00, 8'h7E, 1'b0, 1'b0, -1, 1'b1, 1'b1, 8'h10, 8'hFF);
    run_txn(1'b1, 8'h10, 8'hFF, 8'h00, 1'b1, 1'b0, -1, 1'b0, 1'b0, '0, '0);
    idle_check(1);
    run_txn(1'b1, 8'hA5, 8'h3C, 8'h00, 1'b0, 1'b1, -1, 1'b0, 1'b0, '0, '0);
    idle_check(1);
    run_txn(1'b1, 8'h6B, 8'hE1, 8'h00, 1'b0, 1'b0, 23, 1'b0, 1'b0, '0, '0);
    idle_check(3);
    run_txn(1'b0, 8'h0F, 8'h00, 8'h5D, 1'b0, 1'b0, -1, 1'b0, 1'b0, '0, '0);

    pre = 1'b0;
    cw = 1'($urandom); ca = DW'($urandom); cd = DW'($urandom);
    for (int i = 0; i < 16; i++) begin
      nx = 1'($urandom); nw = 1'($urandom); na = DW'($urandom); nd = DW'($urandom);
      if (i == 15) nx = 1'b0;
      run_txn(cw, ca, cd, DW'($urandom), pre, 1'($urandom), -1, nx, nw, na, nd);
      if (!nx) idle_check($urandom_range(1, 3));
      pre = nx; cw = nw; ca = na; cd = nd;
    end

    sel = 1'b1;
    ts = int'(BS); tp = int'(BP); th = int'(BH); tg = int'(BG);
    @(negedge clk);
    rst_n = 1'b0;
    exp_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(2);
    run_txn(1'b1, 8'h21, 8'h5A, 8'h00, 1'b0, 1'b0, -1, 1'b0, 1'b0, '0, '0);
    idle_check(1);
    run_txn(1'b0, 8'h04, 8'h00, 8'hC3, 1'b0, 1'b0, -1, 1'b1, 1'b0, 8'h55, 8'h00);
    run_txn(1'b0, 8'h55, 8'h00, 8'h9A, 1'b1, 1'b1, -1, 1'b0, 1'b0, '0, '0);
    idle_check(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
